tremolo: RTL and testbench

//  - Amplitude-modulation (tremolo) stage of the guitar pedal board audio chain.
//  - Scales each signed 16-bit sample by a slowly varying gain from an internal triangle LFO.
//  - Runs at the 50 MHz system clock: one sample processed per clock, no handshake.
//  - Sits between the upstream effect and the output stage.

---
 rtl/tremolo.sv | 81 ++++++++
 tb/tb_tremolo.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tremolo.sv
// Tremolo: scales each signed 16-bit sample by a gain driven from a slow triangle LFO.
// Define TREMOLO_SQUARE_EN to switch the applied gain to a square wave (unity / GAIN_MIN).
module tremolo #(
  parameter int LFO_DIV  = 26042,
  parameter int GAIN_MIN = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic signed [15:0] Signal_in,
  output logic signed [15:0] Signal_out
);

  localparam int PW = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(LFO_DIV - 1);
  localparam logic [8:0]    GAIN_UNITY = 9'd256;
  localparam logic [8:0]    GAIN_LOW   = 9'(GAIN_MIN);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  logic [PW-1:0]      presc_reg, presc_next;
  logic [8:0]         gain_reg, gain_next;
  dir_t               dir_reg, dir_next;
  logic [8:0]         gain_eff;
  logic signed [15:0] in_q;
  logic [8:0]         g_q;
  logic signed [25:0] prod;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_reg <= '0;
      gain_reg  <= GAIN_UNITY;
      dir_reg   <= DIR_DOWN;
    end else begin
      presc_reg <= presc_next;
      gain_reg  <= gain_next;
      dir_reg   <= dir_next;
    end
  end

  // Direction flips on the same step that lands on an endpoint, so each endpoint is held one step period.
  always_comb begin
    presc_next = presc_reg + PW'(1);
    gain_next  = gain_reg;
    dir_next   = dir_reg;
    if (presc_reg == PRESC_LAST) begin
      presc_next = '0;
      if (dir_reg == DIR_DOWN) begin
        gain_next = gain_reg - 9'd1;
        if (gain_next == GAIN_LOW) dir_next = DIR_UP;
      end else begin
        gain_next = gain_reg + 9'd1;
        if (gain_next == GAIN_UNITY) dir_next = DIR_DOWN;
      end
    end
  end

`ifdef TREMOLO_SQUARE_EN
  assign gain_eff = (dir_reg == DIR_DOWN) ? GAIN_UNITY : GAIN_LOW;
`else
  assign gain_eff = gain_reg;
`endif

  // Gain is at most unity, so the floored product always fits back into 16 bits.
  assign prod = in_q * $signed({1'b0, g_q});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_q       <= '0;
      g_q        <= '0;
      Signal_out <= '0;
    end else begin
      in_q       <= Signal_in;
      g_q        <= gain_eff;
      Signal_out <= 16'(prod >>> 8);
    end
  end

endmodule

// File: tb/tb_tremolo.sv
// Randomized scoreboard bench for tremolo with a closed-form triangle/square gain model.
module tb_tremolo;
  localparam int LFO_DIV  = 4;
  localparam int GAIN_MIN = 128;
  localparam int DEPTH    = 256 - GAIN_MIN;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic signed [15:0] Signal_in = '0;
  logic signed [15:0] Signal_out;

  always #10 CLK = ~CLK;

  tremolo #(.LFO_DIV(LFO_DIV), .GAIN_MIN(GAIN_MIN)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .Signal_in(Signal_in),
    .Signal_out(Signal_out)
  );

  typedef struct {
    int          due;
    logic [15:0] din;
    int          gain;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic mon_rst;

  // Edges elapsed since the last reset edge.
  always @(posedge CLK) cyc <= RESET ? 0 : cyc + 1;

  // Gain in effect after c post-reset edges: k completed steps along a 2*DEPTH-step triangle.
  function automatic int model_gain(input int c);
    int k;
    int p;
    k = c / LFO_DIV;
    p = k % (2 * DEPTH);
`ifdef TREMOLO_SQUARE_EN
    return (p < DEPTH) ? 256 : GAIN_MIN;
`else
    return (p <= DEPTH) ? 256 - p : 256 - (2 * DEPTH - p);
`endif
  endfunction

  function automatic logic [15:0] model_out(input logic signed [15:0] x, input int g);
    int prod;
    int q;
    prod = int'(x) * g;
    q = prod >>> 8;
    return q[15:0];
  endfunction

  task automatic step(input logic [15:0] x);
    int g;
    @(negedge CLK);
    RESET = 1'b0;
    Signal_in = x;
    g = model_gain(cyc);
    sb.push_back('{cyc + 2, x, g, model_out(x, g)});
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge CLK);
      RESET = 1'b1;
      Signal_in = 16'($urandom);
      sb.delete();
    end
  endtask

  // Monitor: reset edges must clear the output; otherwise pop the entry due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      mon_rst = RESET;
      #1;
      if (mon_rst) begin
        n_tests++;
        if (Signal_out !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_out got=%h exp=0000", Signal_out);
        end else
          $display("[TB] reset out=%h", Signal_out);
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        if (e.due != cyc) begin
          n_fail++;
          $display("FAIL stale_entry due=%0d now=%0d", e.due, cyc);
        end else if (Signal_out !== e.exp) begin
          n_fail++;
          $display("FAIL out cyc=%0d in=%h gain=%0d got=%h exp=%h", cyc, e.din, e.gain, Signal_out, e.exp);
        end else
          $display("[TB] cyc=%0d in=%h gain=%0d out=%h", cyc, e.din, e.gain, Signal_out);
      end
    end
  end

  initial begin
    logic [15:0] x;
    do_reset(3);
    // Full triangle period plus margin; directed samples at unity, zero and the floor-rounding case.
    for (int c = 0; c < 1100; c++) begin
      if (c == 0)        x = 16'h8000;
      else if (c == 1)   x = 16'h0000;
      else if (c == 5)   x = 16'hC04F;
      else if (c < 600)  x = 16'h3FB1;
      else if (c % 7 == 0) x = 16'h0000;
      else               x = 16'($urandom);
      step(x);
    end
    // Ramp to about gain 190, then a one-clock reset mid-ramp.
    do_reset(2);
    for (int c = 0; c < 264; c++) step(16'h3FB1);
    do_reset(1);
    for (int c = 0; c < 40; c++) step((c % 3 == 0) ? 16'h3FB1 : 16'($urandom));
    repeat (4) @(negedge CLK);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
